// File: rtl/memory_responder_if.sv
// Locator/request/response handshake between a memory initiator and a responder.
interface memory_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] locator_bus;
  logic              memory_request;
  logic              memory_mode;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              memory_response;
  logic              busy;
  logic              addr_err;

  modport master (
    output locator_bus, memory_request, memory_mode, data_in,
    input  data_out, memory_response, busy, addr_err
  );

  modport slave (
    input  locator_bus, memory_request, memory_mode, data_in,
    output data_out, memory_response, busy, addr_err
  );
endinterface

// File: rtl/memory_responder.sv
// Single-access memory responder: captures one request, answers with a one-cycle response pulse.
// Optional MEMORY_WRITE_LOCK_EN adds a write_lock input that rejects writes sampled at acceptance.
module memory_responder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 65536,
  parameter int unsigned ACCESS_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef MEMORY_WRITE_LOCK_EN
  input  logic write_lock,
`endif
  memory_responder_if.slave bus
);

  localparam int unsigned CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  // Async assert, two-flop synchronised release
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  logic              lock_in;
`ifdef MEMORY_WRITE_LOCK_EN
  assign lock_in = write_lock;
`else
  assign lock_in = 1'b0;
`endif

  logic [1:0]        state, next_state;
  logic [CNT_W-1:0]  cnt, next_cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_mode;
  logic [DATA_W-1:0] cap_data;
  logic              cap_lock;
  logic              resp_q, err_q, busy_q;
  logic [DATA_W-1:0] dout_q;

  logic capture, do_access, next_resp, next_err, next_busy;
  logic in_range, mem_we, rd_load;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_range = ({1'b0, cap_addr} < DEPTH_L);
  assign mem_we   = do_access && cap_mode && in_range && !cap_lock;
  assign rd_load  = do_access && !cap_mode;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    capture    = 1'b0;
    do_access  = 1'b0;
    next_resp  = 1'b0;
    next_err   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.memory_request) begin
          capture    = 1'b1;
          next_cnt   = CNT_W'(ACCESS_LAT - 1);
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          do_access  = 1'b1;
          next_resp  = 1'b1;
          next_err   = !in_range || (cap_mode && cap_lock);
          next_state = RESPOND;
        end else begin
          next_cnt = cnt - CNT_W'(1);
        end
      end
      // A request still held after the pulse must be dropped before re-arming
      RESPOND: next_state = bus.memory_request ? RELEASE : IDLE;
      RELEASE: if (!bus.memory_request) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    next_busy = (next_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_addr <= '0;
      cap_mode <= 1'b0;
      cap_data <= '0;
      cap_lock <= 1'b0;
      resp_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state  <= next_state;
      cnt    <= next_cnt;
      resp_q <= next_resp;
      err_q  <= next_err;
      busy_q <= next_busy;
      if (capture) begin
        cap_addr <= bus.locator_bus;
        cap_mode <= bus.memory_mode;
        cap_data <= bus.data_in;
        cap_lock <= lock_in;
      end
    end
  end

  // Array is never cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[cap_addr[IDX_W-1:0]] <= cap_data;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)   dout_q <= '0;
    else if (rd_load) dout_q <= in_range ? mem[cap_addr[IDX_W-1:0]] : '0;
  end

  assign bus.data_out        = dout_q;
  assign bus.memory_response = resp_q;
  assign bus.busy            = busy_q;
  assign bus.addr_err        = err_q;

endmodule
